// File: rtl/mux_f_tree_cfg_if.sv
// Bus bundle for the wide-function mux tree: serial configuration chain,
// LUT data and select inputs, output-register enable and slice outputs.
// The master side drives the block; the slave side is the block itself.
interface mux_f_tree_cfg_if #(
   parameter int NUM_LUTS  = 8,
   parameter int MUX_LEVEL = 3
);
   logic                 cen;
   logic                 config_in;
   logic                 config_out;
   logic                 cfg_valid;
   logic [NUM_LUTS-1:0]  luts_out;
   logic [MUX_LEVEL-1:0] addr;
   logic                 ce;
   logic [NUM_LUTS-1:0]  out;

   modport master (
      output cen, config_in, luts_out, addr, ce,
      input  config_out, cfg_valid, out
   );

   modport slave (
      input  cen, config_in, luts_out, addr, ce,
      output config_out, cfg_valid, out
   );
endinterface

// File: rtl/mux_f_tree_cfg.sv
// Wide-function mux tree (F7/F8/F9-style) for the CLB slice.
// A binary tree of 2:1 muxes merges NUM_LUTS LUT outputs into wider
// functions. Each mux has its own enable bit and each output a
// register-select bit. Configuration shifts in serially through a shadow
// chain and is copied into the active register only once a full frame has
// arrived, so a partial load never disturbs the running function.
// Active frame layout: bits [NUM_LUTS-2:0] are mux enables (level 1 nodes
// first, then level 2, up to the root), bits above are reg_sel[0..N-1].
module mux_f_tree_cfg #(
   parameter int NUM_LUTS  = 8,
   parameter int MUX_LEVEL = 3
) (
   input  logic cclk,
   input  logic rst,
   mux_f_tree_cfg_if.slave bus
);

   localparam int CFG_BITS = 2*NUM_LUTS-1;
   localparam int CNT_W    = $clog2(CFG_BITS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CFG_BITS-1);

   logic [CFG_BITS-1:0] shadow;
   logic [CFG_BITS-1:0] active;
   logic [CFG_BITS-1:0] shift_next;
   logic [CNT_W-1:0]    cnt;
   logic                cfg_valid_r;
   logic [NUM_LUTS-2:0] en;
   logic [NUM_LUTS-1:0] reg_sel;
   logic [NUM_LUTS-1:0] comb;
   logic [NUM_LUTS-1:0] q;
   logic [NUM_LUTS-1:0] cur;
   logic [NUM_LUTS-1:0] nxt;

   // The first bit shifted ends up in the MSB, so the last bit of a frame
   // lands in active[0].
   assign shift_next = {shadow[CFG_BITS-2:0], bus.config_in};
   assign en         = active[NUM_LUTS-2:0];
   assign reg_sel    = active[CFG_BITS-1:NUM_LUTS-1];

   // Shadow shift chain and frame counter; the full frame (including the
   // bit arriving on the last edge) commits to active on the final shift.
   always_ff @(posedge cclk or posedge rst) begin
      if (rst) begin
         shadow      <= '0;
         active      <= '0;
         cnt         <= '0;
         cfg_valid_r <= 1'b0;
      end else if (bus.cen) begin
         shadow <= shift_next;
         if (cnt == LAST_CNT) begin
            active      <= shift_next;
            cnt         <= '0;
            cfg_valid_r <= 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Mux tree evaluated level by level; at level k only nodes at multiples
   // of 2^k can swap in their upper neighbour, everything else passes down.
   // Enables for level k start at NUM_LUTS - (NUM_LUTS >> (k-1)).
   always_comb begin
      cur = bus.luts_out;
      nxt = '0;
      for (int k = 1; k <= MUX_LEVEL; k++) begin
         nxt = cur;
         for (int i = 0; i < NUM_LUTS; i += (1 << k)) begin
            if (en[NUM_LUTS - (NUM_LUTS >> (k-1)) + (i >> k)] && bus.addr[k-1]) begin
               nxt[i] = cur[i + (1 << (k-1))];
            end
         end
         cur = nxt;
      end
      comb = cur;
   end

   // Output registers only capture while the block is configured and not
   // being reconfigured, so a config shift always freezes them.
   always_ff @(posedge cclk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (bus.ce && !bus.cen && cfg_valid_r) begin
         q <= comb;
      end
   end

   assign bus.out        = (reg_sel & q) | (~reg_sel & comb);
   assign bus.config_out = shadow[CFG_BITS-1];
   assign bus.cfg_valid  = cfg_valid_r;

endmodule

// File: tb/tb_mux_f_tree_cfg.sv
// Directed bench for mux_f_tree_cfg: reset passthrough, F8 function,
// partial load with pause, registered outputs, reset mid-frame and a
// two-block configuration chain. Inputs change on the falling edge and
// outputs are sampled just after, away from the rising edge.
module tb_mux_f_tree_cfg;

   localparam int NUM_LUTS  = 8;
   localparam int MUX_LEVEL = 3;

   localparam logic [14:0] F8_FRAME   = 15'h007F;
   localparam logic [14:0] PART_FRAME = 15'h4A41;
   localparam logic [14:0] REG_FRAME  = 15'h7F80;
   localparam logic [14:0] RST_FRAME  = 15'h1234;
   localparam logic [14:0] FRAME_A    = 15'h6B1D;
   localparam logic [14:0] FRAME_B    = 15'h3E57;

   logic cclk;
   logic rst;
   int   check_count;
   int   pass_count;

   mux_f_tree_cfg_if #(.NUM_LUTS(NUM_LUTS), .MUX_LEVEL(MUX_LEVEL)) bus_a ();
   mux_f_tree_cfg_if #(.NUM_LUTS(NUM_LUTS), .MUX_LEVEL(MUX_LEVEL)) bus_b ();

   // Second block sits behind the first in the config chain and shares
   // every other input.
   assign bus_b.cen       = bus_a.cen;
   assign bus_b.config_in = bus_a.config_out;
   assign bus_b.luts_out  = bus_a.luts_out;
   assign bus_b.addr      = bus_a.addr;
   assign bus_b.ce        = bus_a.ce;

   mux_f_tree_cfg #(.NUM_LUTS(NUM_LUTS), .MUX_LEVEL(MUX_LEVEL)) dut_a (
      .cclk (cclk),
      .rst  (rst),
      .bus  (bus_a)
   );

   mux_f_tree_cfg #(.NUM_LUTS(NUM_LUTS), .MUX_LEVEL(MUX_LEVEL)) dut_b (
      .cclk (cclk),
      .rst  (rst),
      .bus  (bus_b)
   );

   // Free-running configuration clock, 10 time-unit period.
   initial cclk = 1'b0;
   always #5 cclk = ~cclk;

   // Safety net in case the stimulus ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got === exp) pass_count++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic applyStimulus(input logic [7:0] luts, input logic [2:0] a);
      bus_a.luts_out = luts;
      bus_a.addr     = a;
      #1;
   endtask

   // Shift frame bits hi down to lo, one per rising edge, then drop cen.
   task automatic shiftBits(input logic [14:0] frame, input int hi, input int lo);
      for (int b = hi; b >= lo; b--) begin
         @(negedge cclk);
         bus_a.cen       = 1'b1;
         bus_a.config_in = frame[b];
      end
      @(negedge cclk);
      bus_a.cen       = 1'b0;
      bus_a.config_in = 1'b0;
   endtask

   initial begin
      check_count     = 0;
      pass_count      = 0;
      rst             = 1'b1;
      bus_a.cen       = 1'b0;
      bus_a.config_in = 1'b0;
      bus_a.ce        = 1'b0;
      bus_a.luts_out  = '0;
      bus_a.addr      = '0;
      #12;
      rst = 1'b0;
      @(negedge cclk);

      $display("[TB] reset passthrough");
      applyStimulus(8'hA5, 3'd5);
      checkOutput("rst_out",        32'(bus_a.out),        32'hA5);
      checkOutput("rst_cfg_valid",  32'(bus_a.cfg_valid),  32'd0);
      checkOutput("rst_config_out", 32'(bus_a.config_out), 32'd0);
      checkOutput("rst_cnt",        32'(dut_a.cnt),        32'd0);

      $display("[TB] F8 function");
      applyStimulus(8'h80, 3'b111);
      shiftBits(F8_FRAME, 14, 1);
      checkOutput("f8_pre_out",   32'(bus_a.out),       32'h80);
      checkOutput("f8_pre_valid", 32'(bus_a.cfg_valid), 32'd0);
      shiftBits(F8_FRAME, 0, 0);
      checkOutput("f8_out",       32'(bus_a.out),       32'hD1);
      checkOutput("f8_valid",     32'(bus_a.cfg_valid), 32'd1);
      checkOutput("f8_active",    32'(dut_a.active),    32'h007F);
      checkOutput("f8_cnt",       32'(dut_a.cnt),       32'd0);
      applyStimulus(8'h80, 3'b011);
      checkOutput("f8_addr011",   32'(bus_a.out),       32'hD0);
      applyStimulus(8'h08, 3'b011);
      checkOutput("f8_l3_sel",    32'(bus_a.out),       32'h0D);
      applyStimulus(8'h5A, 3'b000);
      checkOutput("f8_addr000",   32'(bus_a.out),       32'h5A);

      $display("[TB] partial load with pause");
      applyStimulus(8'h10, 3'b111);
      shiftBits(PART_FRAME, 14, 6);
      repeat (5) @(negedge cclk);
      #1;
      checkOutput("part_hold_active", 32'(dut_a.active), 32'h007F);
      checkOutput("part_hold_out",    32'(bus_a.out),    32'h00);
      checkOutput("part_hold_cnt",    32'(dut_a.cnt),    32'd9);
      shiftBits(PART_FRAME, 5, 0);
      checkOutput("part_active",      32'(dut_a.active), 32'h4A41);
      checkOutput("part_out",         32'(bus_a.out),    32'h01);
      checkOutput("part_cnt",         32'(dut_a.cnt),    32'd0);

      $display("[TB] registered outputs");
      applyStimulus(8'h00, 3'b000);
      shiftBits(REG_FRAME, 14, 0);
      checkOutput("reg_active", 32'(dut_a.active), 32'h7F80);
      checkOutput("reg_q_init", 32'(bus_a.out),    32'h00);
      bus_a.ce = 1'b1;
      @(negedge cclk);
      applyStimulus(8'h3C, 3'b000);
      checkOutput("reg_latency", 32'(bus_a.out), 32'h00);
      @(negedge cclk);
      #1;
      checkOutput("reg_capture", 32'(bus_a.out), 32'h3C);
      bus_a.ce = 1'b0;
      applyStimulus(8'hC3, 3'b000);
      @(negedge cclk);
      #1;
      checkOutput("reg_ce_hold", 32'(bus_a.out), 32'h3C);
      bus_a.ce        = 1'b1;
      bus_a.cen       = 1'b1;
      bus_a.config_in = 1'b0;
      @(negedge cclk);
      bus_a.cen = 1'b0;
      #1;
      checkOutput("reg_cen_wins", 32'(bus_a.out), 32'h3C);
      @(negedge cclk);
      #1;
      checkOutput("reg_resume",   32'(bus_a.out), 32'hC3);
      bus_a.ce = 1'b0;

      $display("[TB] reset mid-frame");
      shiftBits(RST_FRAME, 14, 8);
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      checkOutput("mid_cnt",        32'(dut_a.cnt),        32'd0);
      checkOutput("mid_shadow",     32'(dut_a.shadow),     32'd0);
      checkOutput("mid_active",     32'(dut_a.active),     32'd0);
      checkOutput("mid_valid",      32'(bus_a.cfg_valid),  32'd0);
      checkOutput("mid_config_out", 32'(bus_a.config_out), 32'd0);
      applyStimulus(8'h5A, 3'b110);
      checkOutput("mid_passthru",   32'(bus_a.out),        32'h5A);
      shiftBits(RST_FRAME, 14, 0);
      checkOutput("mid_reload_active", 32'(dut_a.active),    32'h1234);
      checkOutput("mid_reload_valid",  32'(bus_a.cfg_valid), 32'd1);
      checkOutput("mid_reload_cnt",    32'(dut_a.cnt),       32'd0);

      $display("[TB] two-block chain");
      shiftBits(FRAME_B, 14, 0);
      checkOutput("chain_a_mid",  32'(dut_a.active),    32'(FRAME_B));
      shiftBits(FRAME_A, 14, 0);
      checkOutput("chain_a",      32'(dut_a.active),    32'(FRAME_A));
      checkOutput("chain_b",      32'(dut_b.active),    32'(FRAME_B));
      checkOutput("chain_b_valid", 32'(bus_b.cfg_valid), 32'd1);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
